// File: rtl/pc_return_stack.sv
`default_nettype none
// ============================================================================
//  Module      : pc_return_stack
//  Description : LIFO return-address stack feeding PC mux input 1. Pushes on
//                CALL (PC+1) or interrupt entry (PC), pops on RET/RETI, with
//                sticky overflow/underflow flags.
//  Revision    : 1.0  initial release
// ============================================================================
module pc_return_stack #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 16,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] PC_COUNT,
    input  logic              PUSH,
    input  logic              INT_PUSH,
    input  logic              POP,
    output logic [ADDR_W-1:0] FROM_STACK,
    output logic [LVL_W-1:0]  SP_LEVEL,
    output logic              EMPTY,
    output logic              FULL,
    output logic              OVF,
    output logic              UNF
);

    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [IDX_W-1:0]  c_IDX_ONE   = IDX_W'(1);
    localparam logic [LVL_W-1:0]  c_LVL_ONE   = LVL_W'(1);
    localparam logic [LVL_W-1:0]  c_LVL_DEPTH = LVL_W'(DEPTH);
    localparam logic [ADDR_W-1:0] c_ADDR_ONE  = ADDR_W'(1);

    logic [ADDR_W-1:0] r_mem [DEPTH];
    logic [LVL_W-1:0]  r_level;
    logic              r_ovf;
    logic              r_unf;

    logic              w_push;
    logic              w_empty;
    logic              w_full;
    logic [ADDR_W-1:0] w_push_val;
    logic [IDX_W-1:0]  w_top_idx;
    logic              w_wr_en;
    logic [IDX_W-1:0]  w_wr_idx;
    logic [LVL_W-1:0]  w_level_nxt;
    logic              w_set_ovf;
    logic              w_set_unf;

    assign w_push     = PUSH | INT_PUSH;
    assign w_empty    = (r_level == '0);
    assign w_full     = (r_level == c_LVL_DEPTH);
    assign w_push_val = INT_PUSH ? PC_COUNT : (PC_COUNT + c_ADDR_ONE);
    // Modulo arithmetic on the low bits maps level DEPTH to index DEPTH-1.
    assign w_top_idx  = r_level[IDX_W-1:0] - c_IDX_ONE;

    always_comb begin
        w_wr_en     = 1'b0;
        w_wr_idx    = r_level[IDX_W-1:0];
        w_level_nxt = r_level;
        w_set_ovf   = 1'b0;
        w_set_unf   = 1'b0;
        if (w_push && POP && !w_empty) begin
            // Simultaneous push/pop replaces the top in place, even when full.
            w_wr_en  = 1'b1;
            w_wr_idx = w_top_idx;
        end else if (w_push && !w_full) begin
            w_wr_en     = 1'b1;
            w_level_nxt = r_level + c_LVL_ONE;
        end else if (w_push) begin
            w_set_ovf = 1'b1;
        end else if (POP && !w_empty) begin
            w_level_nxt = r_level - c_LVL_ONE;
        end else if (POP) begin
            w_set_unf = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_level <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_level <= w_level_nxt;
            r_ovf   <= r_ovf | w_set_ovf;
            r_unf   <= r_unf | w_set_unf;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST && w_wr_en) begin
            r_mem[w_wr_idx] <= w_push_val;
        end
    end

    assign FROM_STACK = w_empty ? '0 : r_mem[w_top_idx];
    assign SP_LEVEL   = r_level;
    assign EMPTY      = w_empty;
    assign FULL       = w_full;
    assign OVF        = r_ovf;
    assign UNF        = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_pc_return_stack.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_return_stack
//  Description : Scoreboard bench for pc_return_stack: directed plan followed
//                by randomized traffic against a queue-based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pc_return_stack;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 16;
    localparam int LVL_W  = 5;

    logic              CLK = 1'b0;
    logic              RST = 1'b0;
    logic [ADDR_W-1:0] PC_COUNT = '0;
    logic              PUSH = 1'b0;
    logic              INT_PUSH = 1'b0;
    logic              POP = 1'b0;
    logic [ADDR_W-1:0] FROM_STACK;
    logic [LVL_W-1:0]  SP_LEVEL;
    logic              EMPTY;
    logic              FULL;
    logic              OVF;
    logic              UNF;

    pc_return_stack #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .PC_COUNT   (PC_COUNT),
        .PUSH       (PUSH),
        .INT_PUSH   (INT_PUSH),
        .POP        (POP),
        .FROM_STACK (FROM_STACK),
        .SP_LEVEL   (SP_LEVEL),
        .EMPTY      (EMPTY),
        .FULL       (FULL),
        .OVF        (OVF),
        .UNF        (UNF)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [LVL_W-1:0]  level;
        logic [ADDR_W-1:0] top;
        logic              empty;
        logic              full;
        logic              ovf;
        logic              unf;
    } exp_t;

    exp_t              sb[$];
    logic [ADDR_W-1:0] m_stk[$];
    logic              m_ovf = 1'b0;
    logic              m_unf = 1'b0;
    int                n_cmp = 0;
    int                n_bad = 0;
    int                n_cyc = 0;

    // Reference: stack as a plain queue, back of the queue is the top.
    task automatic model_step(input logic rst, input logic psh, input logic ip,
                              input logic pp, input logic [ADDR_W-1:0] pc);
        logic [ADDR_W-1:0] val;
        exp_t e;
        val = ip ? pc : ADDR_W'((int'(pc) + 1) % 1024);
        if (rst) begin
            m_stk.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if ((psh || ip) && pp) begin
            if (m_stk.size() > 0) void'(m_stk.pop_back());
            m_stk.push_back(val);
        end else if (psh || ip) begin
            if (m_stk.size() < DEPTH) m_stk.push_back(val);
            else m_ovf = 1'b1;
        end else if (pp) begin
            if (m_stk.size() > 0) void'(m_stk.pop_back());
            else m_unf = 1'b1;
        end
        e.level = LVL_W'(m_stk.size());
        e.top   = (m_stk.size() > 0) ? m_stk[m_stk.size()-1] : '0;
        e.empty = (m_stk.size() == 0);
        e.full  = (m_stk.size() == DEPTH);
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        sb.push_back(e);
    endtask

    task automatic step(input logic rst, input logic psh, input logic ip,
                        input logic pp, input logic [ADDR_W-1:0] pc);
        @(negedge CLK);
        RST = rst; PUSH = psh; INT_PUSH = ip; POP = pp; PC_COUNT = pc;
        model_step(rst, psh, ip, pp, pc);
        @(posedge CLK);
        #2;
    endtask

    task automatic chk(input string name, input int act, input int exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
        end
    endtask

    // Monitor: the DUT presents a fresh state after every edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            n_cyc++;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_cmp++;
                if ({SP_LEVEL, FROM_STACK, EMPTY, FULL, OVF, UNF} !== e) begin
                    n_bad++;
                    $display("FAIL scoreboard cyc=%0d: got lvl=%0d top=%h e=%b f=%b o=%b u=%b, expected lvl=%0d top=%h e=%b f=%b o=%b u=%b",
                             n_cyc, SP_LEVEL, FROM_STACK, EMPTY, FULL, OVF, UNF,
                             e.level, e.top, e.empty, e.full, e.ovf, e.unf);
                end
            end
        end
    end

    initial begin
        // Reset / empty
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("reset_level", SP_LEVEL, 0);
        chk("reset_empty", EMPTY, 1);
        chk("reset_full", FULL, 0);
        chk("reset_top", FROM_STACK, 0);
        chk("reset_flags", {OVF, UNF}, 0);

        // CALL / RET
        step(0, 1, 0, 0, 10'h028);
        chk("call1_top", FROM_STACK, 10'h029);
        chk("call1_level", SP_LEVEL, 1);
        step(0, 1, 0, 0, 10'h00F);
        chk("call2_top", FROM_STACK, 10'h010);
        chk("call2_level", SP_LEVEL, 2);
        step(0, 0, 0, 1, 0);
        chk("ret1_top", FROM_STACK, 10'h029);
        step(0, 0, 0, 1, 0);
        chk("ret2_empty", EMPTY, 1);
        chk("ret2_top", FROM_STACK, 0);

        // Wrap and interrupt priority
        step(0, 1, 0, 0, 10'h3FF);
        chk("wrap_top", FROM_STACK, 10'h000);
        step(0, 1, 1, 0, 10'h155);
        chk("int_top", FROM_STACK, 10'h155);
        chk("int_level", SP_LEVEL, 2);

        // Full / overflow
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 0, ADDR_W'(i));
        chk("full_flag", FULL, 1);
        chk("full_top", FROM_STACK, 10'h010);
        step(0, 1, 0, 0, 10'h200);
        chk("ovf_level", SP_LEVEL, 16);
        chk("ovf_top", FROM_STACK, 10'h010);
        chk("ovf_flag", OVF, 1);
        step(0, 1, 0, 1, 10'h100);
        chk("replace_top", FROM_STACK, 10'h101);
        chk("replace_level", SP_LEVEL, 16);
        chk("replace_ovf_kept", OVF, 1);

        // Reset mid-operation: drain to level 3 with OVF still set
        for (int i = 0; i < 13; i++) step(0, 0, 0, 1, 0);
        chk("drain_level", SP_LEVEL, 3);
        chk("drain_top", FROM_STACK, 10'h003);
        step(1, 1, 0, 0, 10'h0AA);
        chk("rst_mid_level", SP_LEVEL, 0);
        chk("rst_mid_ovf", OVF, 0);
        chk("rst_mid_top", FROM_STACK, 0);

        // Underflow
        step(0, 0, 0, 1, 0);
        chk("unf_flag", UNF, 1);
        chk("unf_level", SP_LEVEL, 0);
        step(0, 1, 0, 0, 10'h050);
        chk("unf_sticky", UNF, 1);
        step(0, 0, 0, 1, 0);
        step(0, 1, 0, 1, 10'h020);
        chk("pushpop_empty_level", SP_LEVEL, 1);
        chk("pushpop_empty_top", FROM_STACK, 10'h021);

        // Randomized traffic, occasionally biased toward filling
        for (int i = 0; i < 3000; i++) begin
            logic r, p, ip, pp;
            int bias;
            bias = (i / 500) % 2;
            r  = ($urandom_range(0, 199) == 0);
            p  = ($urandom_range(0, 99) < (bias ? 60 : 35));
            ip = ($urandom_range(0, 99) < 15);
            pp = ($urandom_range(0, 99) < (bias ? 25 : 45));
            step(r, p, ip, pp, ADDR_W'($urandom_range(0, 1023)));
        end

        @(negedge CLK);
        RST = 0; PUSH = 0; INT_PUSH = 0; POP = 0;
        repeat (3) @(posedge CLK);
        #3;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
